// File: rtl/wos_seq_pkg.sv
// wos_seq_pkg: mode and FSM state encodings shared by the stream sequencer
package wos_seq_pkg;
   localparam logic [1:0] MODE_SINGLE = 2'b00;
   localparam logic [1:0] MODE_LOOP   = 2'b01;
   localparam logic [1:0] MODE_STEP   = 2'b10;
   typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/wrap_updown_ctr.sv
// wrap_updown_ctr: modulo up/down counter; simultaneous up and down cancel
module wrap_updown_ctr #(
   parameter int WIDTH   = 8,
   parameter int MODULUS = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up,
   input  logic             down,
   output logic [WIDTH-1:0] count
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) count <= '0;
      else if (up && !down) count <= count == MAX ? '0 : count + 1'b1;
      else if (down && !up) count <= count == '0 ? MAX : count - 1'b1;
endmodule

// File: rtl/wos_stream_sequencer.sv
// wos_stream_sequencer: streams source ROM samples through the rank-order filter
// and writes latency-aligned results to the result RAM at their source address.
module wos_stream_sequencer
   import wos_seq_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 8,
   parameter int N_SAMPLES = 255,
   parameter int LATENCY   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic                 step,
   input  logic                 abort,
   input  logic                 rd_up,
   input  logic                 rd_down,
   output logic [ADDR_BITS-1:0] src_addr,
   input  logic [DATA_BITS-1:0] src_data,
   output logic                 filt_clr,
   output logic                 filt_en,
   output logic [DATA_BITS-1:0] filt_in,
   input  logic [DATA_BITS-1:0] filt_out,
   output logic                 res_we,
   output logic [ADDR_BITS-1:0] res_waddr,
   output logic [DATA_BITS-1:0] res_wdata,
   output logic [ADDR_BITS-1:0] res_raddr,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           run_count
);
   localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(N_SAMPLES - 1);

   state_t               state, nxt;
   logic [1:0]           mode_q;
   logic [ADDR_BITS-1:0] in_cnt, out_cnt;
   logic [LATENCY-1:0]   vld;
   logic                 run_ph, adv, wr, go, kill;

   assign run_ph = state == S_RUN || state == S_DRAIN;
   assign adv    = run_ph && !abort && (mode_q != MODE_STEP || step);
   assign wr     = adv && vld[LATENCY-1];
   assign kill   = abort && (run_ph || state == S_PRIME);
   assign go     = nxt == S_PRIME;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= S_IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = start ? S_PRIME : S_IDLE;
         S_PRIME: nxt = abort ? S_IDLE : S_RUN;
         S_RUN:   nxt = abort ? S_IDLE : (adv && in_cnt == LAST) ? S_DRAIN : S_RUN;
         S_DRAIN: nxt = abort ? S_IDLE : (wr && out_cnt == LAST) ? S_DONE : S_DRAIN;
         S_DONE:  nxt = (start || mode_q == MODE_LOOP) ? S_PRIME : S_DONE;
         default: nxt = S_IDLE;
      endcase
   end

   // src_addr looks one sample ahead on an advance so the 1-cycle ROM keeps pace
   always_comb begin
      busy      = state == S_PRIME || run_ph;
      done      = state == S_DONE;
      filt_clr  = state == S_PRIME;
      filt_en   = adv;
      filt_in   = (adv && state == S_RUN) ? src_data : '0;
      src_addr  = (adv && state == S_RUN) ? in_cnt + 1'b1 : in_cnt;
      res_we    = wr;
      res_waddr = out_cnt;
      res_wdata = wr ? filt_out : '0;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         mode_q    <= MODE_SINGLE;
         in_cnt    <= '0;
         out_cnt   <= '0;
         vld       <= '0;
         run_count <= '0;
      end else begin
         if (kill || go) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            vld     <= '0;
         end else if (adv) begin
            vld     <= (vld << 1) | LATENCY'(state == S_RUN);
            in_cnt  <= state == S_RUN ? in_cnt + 1'b1 : in_cnt;
            out_cnt <= wr ? out_cnt + 1'b1 : out_cnt;
         end
         if (start && (state == S_IDLE || state == S_DONE))
            mode_q <= (mode == MODE_LOOP || mode == MODE_STEP) ? mode : MODE_SINGLE;
         if (state == S_DRAIN && nxt == S_DONE && run_count != 8'hFF)
            run_count <= run_count + 1'b1;
      end

   wrap_updown_ctr #(.WIDTH(ADDR_BITS), .MODULUS(N_SAMPLES)) u_rd (
      .clk  (clk),
      .rst  (rst),
      .up   (rd_up),
      .down (rd_down),
      .count(res_raddr)
   );
endmodule

// File: tb/tb_wos_stream_sequencer.sv
// tb_wos_stream_sequencer: directed bench with ROM[i]=i+10 and a 2-deep identity filter
module tb_wos_stream_sequencer;
   localparam int N = 8;
   logic       clk = 0, rst = 0, start = 0, step = 0, abort = 0, rd_up = 0, rd_down = 0;
   logic [1:0] mode = 0;
   logic [7:0] src_addr, src_data, filt_in, filt_out, res_waddr, res_wdata, res_raddr, run_count;
   logic       filt_clr, filt_en, res_we, busy, done;
   logic [7:0] p0, p1;
   int n_run = 0, n_fail = 0, wr_n = 0, busy_n = 0, clr_n = 0, en_n = 0, exp_addr = 0;
   int b_w, b_b, b_c, b_e;

   always #5 clk = ~clk;
   always @(posedge clk) src_data <= src_addr + 8'd10;
   always @(posedge clk)
      if (filt_clr) begin
         p0 <= 0;
         p1 <= 0;
      end else if (filt_en) begin
         p0 <= filt_in;
         p1 <= p0;
      end
   assign filt_out = p1;

   wos_stream_sequencer #(.DATA_BITS(8), .ADDR_BITS(8), .N_SAMPLES(N), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .step(step), .abort(abort),
      .rd_up(rd_up), .rd_down(rd_down), .src_addr(src_addr), .src_data(src_data),
      .filt_clr(filt_clr), .filt_en(filt_en), .filt_in(filt_in), .filt_out(filt_out),
      .res_we(res_we), .res_waddr(res_waddr), .res_wdata(res_wdata), .res_raddr(res_raddr),
      .busy(busy), .done(done), .run_count(run_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      if (busy) busy_n++;
      if (filt_clr) clr_n++;
      if (filt_en) en_n++;
      if (res_we) begin
         wr_n++;
         chk("wr_addr", res_waddr, exp_addr);
         chk("wr_data", res_wdata, res_waddr + 10);
         exp_addr = (exp_addr + 1) % N;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      b_w = wr_n;
      b_b = busy_n;
      b_c = clr_n;
      b_e = en_n;
   endtask

   task automatic run_start(input logic [1:0] m);
      mode = m;
      start = 1;
      exp_addr = 0;
      cyc();
      start = 0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 100 && !done; i++) cyc();
      chk(tag, done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) cyc();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rc", run_count, 0);
      chk("rst_src", src_addr, 0);
      chk("rst_we", res_we, 0);
      chk("rst_en", filt_en, 0);
      chk("rst_clr", filt_clr, 0);
      chk("rst_raddr", res_raddr, 0);
      rst = 1;
      cyc();
      // single run
      snap();
      run_start(2'b00);
      wait_done("single_done");
      chk("single_busy", busy_n - b_b, 11);
      chk("single_wr", wr_n - b_w, 8);
      chk("single_en", en_n - b_e, 10);
      chk("single_clr", clr_n - b_c, 1);
      chk("single_rc", run_count, 1);
      cyc();
      chk("single_hold", done, 1);
      // step mode
      snap();
      run_start(2'b10);
      repeat (3) cyc();
      chk("step_noen", en_n - b_e, 0);
      for (int s = 0; s < 5; s++) begin
         step = 1;
         cyc();
         step = 0;
         repeat (2) cyc();
      end
      chk("step_mid_wr", wr_n - b_w, 3);
      chk("step_mid_en", en_n - b_e, 5);
      for (int s = 0; s < 5; s++) begin
         step = 1;
         cyc();
         step = 0;
         repeat (2) cyc();
      end
      chk("step_done", done, 1);
      chk("step_wr", wr_n - b_w, 8);
      chk("step_en", en_n - b_e, 10);
      chk("step_rc", run_count, 2);
      // abort after the 4th sample
      snap();
      run_start(2'b00);
      cyc();
      repeat (4) cyc();
      abort = 1;
      cyc();
      abort = 0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_wr", wr_n - b_w, 2);
      chk("abort_rc", run_count, 2);
      repeat (5) cyc();
      chk("abort_quiet", wr_n - b_w, 2);
      run_start(2'b00);
      wait_done("clean_done");
      chk("clean_wr", wr_n - b_w, 10);
      chk("clean_rc", run_count, 3);
      // loop mode, with a stray start and mode change mid-run
      snap();
      run_start(2'b01);
      for (int i = 0; i < 200 && run_count != 6; i++) begin
         start = (i == 5);
         if (i == 5) mode = 2'b00;
         cyc();
      end
      start = 0;
      chk("loop_rc", run_count, 6);
      chk("loop_clr", clr_n - b_c, 3);
      chk("loop_wr", wr_n - b_w, 24);
      chk("loop_done", done, 1);
      cyc();
      chk("loop_restart", busy, 1);
      abort = 1;
      cyc();
      abort = 0;
      chk("loop_abort_busy", busy, 0);
      chk("loop_abort_done", done, 0);
      chk("loop_abort_rc", run_count, 6);
      // readback pointer
      chk("rd_init", res_raddr, 0);
      rd_down = 1;
      cyc();
      rd_down = 0;
      chk("rd_wrap_down", res_raddr, 7);
      rd_up = 1;
      cyc();
      rd_up = 0;
      chk("rd_wrap_up", res_raddr, 0);
      rd_up = 1;
      repeat (3) cyc();
      rd_up = 0;
      chk("rd_up3", res_raddr, 3);
      rd_up = 1;
      rd_down = 1;
      cyc();
      rd_up = 0;
      rd_down = 0;
      chk("rd_both", res_raddr, 3);
      rd_down = 1;
      cyc();
      rd_down = 0;
      chk("rd_down", res_raddr, 2);
      // async reset mid-run
      run_start(2'b00);
      repeat (4) cyc();
      chk("pre_rst_busy", busy, 1);
      rst = 0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_en", filt_en, 0);
      chk("arst_we", res_we, 0);
      chk("arst_src", src_addr, 0);
      chk("arst_rc", run_count, 0);
      chk("arst_done", done, 0);
      chk("arst_clr", filt_clr, 0);
      chk("arst_raddr", res_raddr, 0);
      repeat (2) cyc();
      rst = 1;
      snap();
      repeat (5) cyc();
      chk("post_rst_quiet", wr_n - b_w, 0);
      chk("post_rst_busy", busy, 0);
      run_start(2'b00);
      wait_done("post_rst_done");
      chk("post_rst_wr", wr_n - b_w, 8);
      chk("post_rst_rc", run_count, 1);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
